// File: rtl/rv_pkg.sv
// Shared register-file types and constants for the pipelined core.
// Also holds the out-of-range test for register addresses.
package rv_pkg;

   localparam int REG_AW = 5;

   typedef enum logic {RF_INIT, RF_RUN} rf_state_t;

   localparam logic [REG_AW-1:0] X0 = 5'd0;

   // RV32E only implements x0..x15, so upper addresses are illegal there
   function automatic logic addr_oob(input logic [REG_AW-1:0] a, input int nregs);
      return ({1'b0, a} >= 6'(nregs));
   endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy flags used by decode for RAW stall detection.
// Issue sets a flag, writeback clears it; issue wins on a same-edge collision.
module rf_scoreboard
   import rv_pkg::*;
#(
   parameter int NREGS = 32,
   parameter int NRD   = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  i_set,
   input  logic [REG_AW-1:0]     i_set_rd,
   input  logic                  i_clr,
   input  logic [REG_AW-1:0]     i_clr_rd,
   input  logic [NRD*REG_AW-1:0] i_ra,
   output logic [NRD-1:0]        o_busy
);

   localparam int IW = $clog2(NREGS);

   logic [NREGS-1:0] r_busy;
   logic [NREGS-1:0] w_busy_nxt;

   // next busy vector; a new producer keeps the register busy even if an older one retires
   always_comb begin
      w_busy_nxt = '0;
      for (int r = 1; r < NREGS; r++) begin
         w_busy_nxt[r] = (i_set && (i_set_rd == REG_AW'(r))) ||
                         (r_busy[r] && !(i_clr && (i_clr_rd == REG_AW'(r))));
      end
   end

   // busy flag storage
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_busy <= '0;
      end else begin
         r_busy <= w_busy_nxt;
      end
   end

   // per-read-port busy lookup
   always_comb begin
      o_busy = '0;
      for (int i = 0; i < NRD; i++) begin
         if (addr_oob(i_ra[REG_AW*i +: REG_AW], NREGS)) begin
            o_busy[i] = 1'b0;
         end else begin
            o_busy[i] = r_busy[i_ra[REG_AW*i +: IW]];
         end
      end
   end

endmodule

// File: rtl/reg_file_sb.sv
// Integer register file with x0 hardwired to zero, optional write-to-read bypass,
// a sequential post-reset clear of the array and a RAW busy scoreboard.
module reg_file_sb
   import rv_pkg::*;
#(
   parameter int XLEN   = 32,
   parameter int NREGS  = 32,
   parameter int NRD    = 2,
   parameter int BYPASS = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   output logic                  init_done,
   input  logic [NRD*REG_AW-1:0] ra,
   output logic [NRD*XLEN-1:0]   rd,
   output logic [NRD-1:0]        rbusy,
   input  logic                  we,
   input  logic [REG_AW-1:0]     wa,
   input  logic [XLEN-1:0]       wd,
   input  logic                  iss_valid,
   input  logic [REG_AW-1:0]     iss_rd,
   output logic                  addr_err
);

   localparam int IW = $clog2(NREGS);
   localparam logic [REG_AW-1:0] LAST = REG_AW'(NREGS - 1);

   rf_state_t         r_state;
   rf_state_t         w_state_nxt;
   logic [REG_AW-1:0] r_cnt;
   logic              r_init_done;
   logic              r_addr_err;
   logic [XLEN-1:0]   r_x [1:NREGS-1];

   logic              w_run;
   logic              w_wr_ok;
   logic              w_iss_ok;
   logic              w_err_nxt;
   logic [NRD-1:0]    w_fwd;
   logic [NRD-1:0]    w_busy_rd;

   assign w_run    = (r_state == RF_RUN);
   assign w_wr_ok  = w_run & we & (wa != X0) & ~addr_oob(wa, NREGS);
   assign w_iss_ok = w_run & iss_valid & ~addr_oob(iss_rd, NREGS);

   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= RF_INIT;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // next-state: leave INIT once the last register has been cleared
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         RF_INIT: begin
            if (r_cnt == LAST) begin
               w_state_nxt = RF_RUN;
            end else begin
               w_state_nxt = RF_INIT;
            end
         end
         RF_RUN:  w_state_nxt = RF_RUN;
         default: w_state_nxt = RF_INIT;
      endcase
   end

   // illegal-address detection across all enabled accesses
   always_comb begin
      w_err_nxt = 1'b0;
      for (int i = 0; i < NRD; i++) begin
         w_err_nxt = w_err_nxt | addr_oob(ra[REG_AW*i +: REG_AW], NREGS);
      end
      w_err_nxt = w_run & (w_err_nxt | (we & addr_oob(wa, NREGS)) |
                                       (iss_valid & addr_oob(iss_rd, NREGS)));
   end

   // clear counter and registered status outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt       <= 5'd1;
         r_init_done <= 1'b0;
         r_addr_err  <= 1'b0;
      end else begin
         if (r_state == RF_INIT) begin
            r_cnt <= r_cnt + 5'd1;
         end else begin
            r_cnt <= r_cnt;
         end
         r_init_done <= (w_state_nxt == RF_RUN);
         r_addr_err  <= w_err_nxt;
      end
   end

   // storage array is deliberately reset-free; INIT walks it to zero instead
   always_ff @(posedge clk) begin
      if (r_state == RF_INIT) begin
         r_x[r_cnt[IW-1:0]] <= '0;
      end else if (w_wr_ok) begin
         r_x[wa[IW-1:0]] <= wd;
      end
   end

   // combinational read ports with optional same-cycle forwarding
   always_comb begin
      rd    = '0;
      w_fwd = '0;
      for (int i = 0; i < NRD; i++) begin
         if (!w_run || (ra[REG_AW*i +: REG_AW] == X0) ||
             addr_oob(ra[REG_AW*i +: REG_AW], NREGS)) begin
            rd[XLEN*i +: XLEN] = '0;
         end else if ((BYPASS != 0) && we && (wa == ra[REG_AW*i +: REG_AW])) begin
            rd[XLEN*i +: XLEN] = wd;
            w_fwd[i]           = 1'b1;
         end else begin
            rd[XLEN*i +: XLEN] = r_x[ra[REG_AW*i +: IW]];
         end
      end
   end

   rf_scoreboard #(
      .NREGS (NREGS),
      .NRD   (NRD)
   ) u_sb (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_set    (w_iss_ok),
      .i_set_rd (iss_rd),
      .i_clr    (w_wr_ok),
      .i_clr_rd (wa),
      .i_ra     (ra),
      .o_busy   (w_busy_rd)
   );

   // forwarded data is already available, so it must not stall decode
   assign rbusy     = w_busy_rd & ~w_fwd & {NRD{w_run}};
   assign init_done = r_init_done;
   assign addr_err  = r_addr_err;

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed self-checking bench: RV32I with bypass, RV32E with bypass and RV32I
// without bypass all share one stimulus stream.
module tb_reg_file_sb;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [9:0]  ra;
   logic        we;
   logic [4:0]  wa;
   logic [31:0] wd;
   logic        iss_valid;
   logic [4:0]  iss_rd;

   logic        init_done_a, init_done_e, init_done_n;
   logic [63:0] rd_a, rd_e, rd_n;
   logic [1:0]  rbusy_a, rbusy_e, rbusy_n;
   logic        addr_err_a, addr_err_e, addr_err_n;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   reg_file_sb #(.XLEN(32), .NREGS(32), .NRD(2), .BYPASS(1)) dut_a (
      .clk(clk), .rst_n(rst_n), .init_done(init_done_a), .ra(ra), .rd(rd_a),
      .rbusy(rbusy_a), .we(we), .wa(wa), .wd(wd), .iss_valid(iss_valid),
      .iss_rd(iss_rd), .addr_err(addr_err_a));

   reg_file_sb #(.XLEN(32), .NREGS(16), .NRD(2), .BYPASS(1)) dut_e (
      .clk(clk), .rst_n(rst_n), .init_done(init_done_e), .ra(ra), .rd(rd_e),
      .rbusy(rbusy_e), .we(we), .wa(wa), .wd(wd), .iss_valid(iss_valid),
      .iss_rd(iss_rd), .addr_err(addr_err_e));

   reg_file_sb #(.XLEN(32), .NREGS(32), .NRD(2), .BYPASS(0)) dut_n (
      .clk(clk), .rst_n(rst_n), .init_done(init_done_n), .ra(ra), .rd(rd_n),
      .rbusy(rbusy_n), .we(we), .wa(wa), .wd(wd), .iss_valid(iss_valid),
      .iss_rd(iss_rd), .addr_err(addr_err_n));

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      we        = 1'b0;
      wa        = 5'd0;
      wd        = 32'd0;
      iss_valid = 1'b0;
      iss_rd    = 5'd0;
      ra        = 10'd0;
   endtask

   int          na, ne, nn;
   logic [31:0] acc_a, acc_e;

   initial begin
      idle();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      ra    = 10'd5;
      #1;
      check("rst_init_done", {init_done_a, init_done_e, init_done_n}, 64'd0);
      check("rst_rbusy", {rbusy_a, rbusy_e, rbusy_n}, 64'd0);
      check("rst_addr_err", {addr_err_a, addr_err_e, addr_err_n}, 64'd0);
      check("init_rd_zero", rd_a, 64'd0);

      // 1. clear sequence length
      na = 0; ne = 0; nn = 0;
      for (int c = 1; c <= 40; c++) begin
         step();
         if (init_done_a && na == 0) na = c;
         if (init_done_e && ne == 0) ne = c;
         if (init_done_n && nn == 0) nn = c;
      end
      check("init_cycles_32", 64'(na), 64'd31);
      check("init_cycles_16", 64'(ne), 64'd15);
      check("init_cycles_nb", 64'(nn), 64'd31);

      acc_a = 32'd0;
      acc_e = 32'd0;
      for (int r = 1; r < 32; r++) begin
         ra = 10'(r);
         #1;
         acc_a = acc_a | rd_a[31:0];
         if (r < 16) acc_e = acc_e | rd_e[31:0];
      end
      check("cleared_32", 64'(acc_a), 64'd0);
      check("cleared_16", 64'(acc_e), 64'd0);
      ra = 10'd0;

      // 2. write, read back, x0 discard
      we = 1'b1; wa = 5'd5; wd = 32'hDEADBEEF;
      step();
      idle();
      ra = 10'd5;
      #1;
      check("wr_rd_x5", rd_a[31:0], 32'hDEADBEEF);
      we = 1'b1; wa = 5'd0; wd = 32'h1234; ra = 10'd0;
      #1;
      check("x0_bypass", rd_a[31:0], 32'd0);
      step();
      idle();
      #1;
      check("x0_read", rd_a[31:0], 32'd0);

      // 3. bypass: x7 old value with a pending producer, then forward new data
      we = 1'b1; wa = 5'd7; wd = 32'h11111111; iss_valid = 1'b1; iss_rd = 5'd7;
      step();
      idle();
      ra = {5'd7, 5'd0};
      #1;
      check("busy_set_prio", rbusy_a[1], 1'b1);
      we = 1'b1; wa = 5'd7; wd = 32'hA5A5A5A5;
      #1;
      check("byp_rd", rd_a[63:32], 32'hA5A5A5A5);
      check("byp_rbusy", rbusy_a[1], 1'b0);
      check("nobyp_rd", rd_n[63:32], 32'h11111111);
      check("nobyp_rbusy", rbusy_n[1], 1'b1);
      step();
      we = 1'b0;
      #1;
      check("nobyp_after", rd_n[63:32], 32'hA5A5A5A5);
      check("busy_cleared7", rbusy_a[1], 1'b0);

      // 4. scoreboard set / priority / clear
      idle();
      iss_valid = 1'b1; iss_rd = 5'd3;
      step();
      idle();
      ra = 10'd3;
      #1;
      check("sb_set", rbusy_a[0], 1'b1);
      we = 1'b1; wa = 5'd3; wd = 32'h33; iss_valid = 1'b1; iss_rd = 5'd3;
      step();
      we = 1'b0; iss_valid = 1'b0;
      #1;
      check("sb_prio", rbusy_a[0], 1'b1);
      we = 1'b1; wa = 5'd3; wd = 32'h34;
      step();
      we = 1'b0;
      #1;
      check("sb_clr", rbusy_a[0], 1'b0);
      check("sb_clr_data", rd_a[31:0], 32'h34);

      // 5. RV32E bounds: wa=20 aliases x4 in the low bits but must be dropped
      idle();
      we = 1'b1; wa = 5'd20; wd = 32'hCAFEF00D;
      step();
      idle();
      ra = 10'd4;
      #1;
      check("e_err_pulse", addr_err_e, 1'b1);
      check("a_no_err", addr_err_a, 1'b0);
      check("e_x4_kept", rd_e[31:0], 32'd0);
      step();
      check("e_err_1cyc", addr_err_e, 1'b0);
      ra = 10'd20;
      #1;
      check("e_rd_oob", rd_e[31:0], 32'd0);
      step();
      check("e_ra_err", addr_err_e, 1'b1);
      ra = 10'd0;

      // 6. asynchronous reset mid-run
      we = 1'b1; wa = 5'd4; wd = 32'd5; iss_valid = 1'b1; iss_rd = 5'd4;
      step();
      idle();
      ra = 10'd4;
      #1;
      check("pre_rst_x4", rd_a[31:0], 32'd5);
      check("pre_rst_busy", rbusy_a[0], 1'b1);
      #1;
      rst_n = 1'b0;
      #1;
      check("mid_rst_init_done", init_done_a, 1'b0);
      check("mid_rst_rbusy", rbusy_a[0], 1'b0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      na = 0;
      for (int c = 1; c <= 40; c++) begin
         step();
         if (init_done_a && na == 0) na = c;
      end
      check("rerun_cycles", 64'(na), 64'd31);
      check("post_rst_x4", rd_a[31:0], 32'd0);
      check("post_rst_busy", rbusy_a[0], 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
